// File: rtl/jtag_tap_pkg.sv
// JTAG TAP shared types and constants.
// TAP state encoding and instruction codes.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SH_DR,
    EX1_DR,
    PAUSE_DR,
    EX2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SH_IR,
    EX1_IR,
    PAUSE_IR,
    EX2_IR,
    UPD_IR
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_USER    = 5'h10;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

endpackage

// File: rtl/jtag_pin_sync.sv
// JTAG pin synchronizers into the clk domain.
// TCK edges come from a third flop behind the synchronizer.
module jtag_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trst_n,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_s_n
);

  logic [1:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic [1:0] trst_q;
  logic       tck_prev_q;

  // two-flop synchronizers, all at the same depth as TCK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      trst_q     <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[0], tck};
      tms_q      <= {tms_q[0], tms};
      tdi_q      <= {tdi_q[0], tdi};
      trst_q     <= {trst_q[0], trst_n};
      tck_prev_q <= tck_q[1];
    end
  end

  assign tck_rise = tck_q[1] & ~tck_prev_q;
  assign tck_fall = ~tck_q[1] & tck_prev_q;
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trst_s_n = trst_q[1];

endmodule

// File: rtl/jtag_sync_tap.sv
// Oversampled JTAG TAP with IDCODE, BYPASS and USER.
// USER has a capture/update handshake towards SoC logic.
module jtag_sync_tap #(
  parameter int unsigned   IrLength  = 5,
  parameter logic [31:0]   IdCode    = 32'h04F5484D,
  parameter int unsigned   UserWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jtag_tck_i,
  input  logic                 jtag_tms_i,
  input  logic                 jtag_tdi_i,
  input  logic                 jtag_trst_ni,
  output logic                 jtag_tdo_o,
  output logic                 jtag_tdo_oe_o,
  input  logic [UserWidth-1:0] user_cap_data_i,
  output logic                 user_cap_o,
  output logic                 user_upd_valid_o,
  output logic [UserWidth-1:0] user_upd_data_o
);

  import jtag_tap_pkg::*;

  localparam logic [IrLength-1:0] IrIdcode =
    IrLength'(IR_IDCODE);
  localparam logic [IrLength-1:0] IrUser =
    IrLength'(IR_USER);
  localparam logic [IrLength-1:0] IrCapture =
    IrLength'(IR_CAPTURE);

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;
  logic trst_s_n;

  jtag_pin_sync u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .tck      (jtag_tck_i),
    .tms      (jtag_tms_i),
    .tdi      (jtag_tdi_i),
    .trst_n   (jtag_trst_ni),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .trst_s_n (trst_s_n)
  );

  tap_state_e state_q;
  tap_state_e state_d;

  logic [IrLength-1:0]  ir_q;
  logic [IrLength-1:0]  ir_sr_q;
  logic [31:0]          idcode_sr_q;
  logic                 bypass_sr_q;
  logic [UserWidth-1:0] user_sr_q;
  logic [UserWidth:0]   user_shift;

  logic sel_idcode;
  logic sel_user;
  logic sel_bypass;
  logic dr_lsb;
  logic rise_ok;

  assign rise_ok    = tck_rise & trst_s_n;
  assign user_shift = {tdi_s, user_sr_q};

  // TAP state register; synced TRST forces TLR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          state_q <= TLR;
    else if (!trst_s_n) state_q <= TLR;
    else                state_q <= state_d;
  end

  // 1149.1 next-state table, advanced on TCK rise
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:      state_d = tms_s ? TLR    : RTI;
        RTI:      state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:   state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:    state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:   state_d = tms_s ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_d = tms_s ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:   state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:   state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:    state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:   state_d = tms_s ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_d = tms_s ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:   state_d = tms_s ? SEL_DR : RTI;
      endcase
    end
  end

  // instruction decode; unknown codes fall back to BYPASS
  always_comb begin
    sel_idcode = 1'b0;
    sel_user   = 1'b0;
    sel_bypass = 1'b0;
    unique case (1'b1)
      (ir_q == IrIdcode): sel_idcode = 1'b1;
      (ir_q == IrUser):   sel_user   = 1'b1;
      default:            sel_bypass = 1'b1;
    endcase
  end

  // LSB of the selected data register
  always_comb begin
    dr_lsb = bypass_sr_q;
    unique case (1'b1)
      sel_idcode: dr_lsb = idcode_sr_q[0];
      sel_user:   dr_lsb = user_sr_q[0];
      default:    dr_lsb = bypass_sr_q;
    endcase
  end

  // instruction register and its shift stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q    <= IrIdcode;
      ir_sr_q <= '0;
    end else if (!trst_s_n || state_q == TLR) begin
      ir_q    <= IrIdcode;
    end else if (tck_rise) begin
      unique case (state_q)
        CAP_IR:  ir_sr_q <= IrCapture;
        SH_IR:   ir_sr_q <= {tdi_s, ir_sr_q[IrLength-1:1]};
        UPD_IR:  ir_q    <= ir_sr_q;
        default: ;
      endcase
    end
  end

  // data registers: capture and shift the selected one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idcode_sr_q <= '0;
      bypass_sr_q <= 1'b0;
      user_sr_q   <= '0;
    end else if (rise_ok) begin
      unique case (state_q)
        CAP_DR: begin
          if (sel_idcode) idcode_sr_q <= IdCode;
          if (sel_bypass) bypass_sr_q <= 1'b0;
          if (sel_user)   user_sr_q   <= user_cap_data_i;
        end
        SH_DR: begin
          if (sel_idcode)
            idcode_sr_q <= {tdi_s, idcode_sr_q[31:1]};
          if (sel_bypass) bypass_sr_q <= tdi_s;
          if (sel_user)
            user_sr_q <= user_shift[UserWidth:1];
        end
        default: ;
      endcase
    end
  end

  // USER capture/update pulses and held update data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      user_cap_o       <= 1'b0;
      user_upd_valid_o <= 1'b0;
      user_upd_data_o  <= '0;
    end else begin
      user_cap_o <=
        rise_ok & sel_user & (state_q == CAP_DR);
      user_upd_valid_o <=
        rise_ok & sel_user & (state_q == UPD_DR);
      if (rise_ok && sel_user && state_q == UPD_DR)
        user_upd_data_o <= user_sr_q;
    end
  end

  // TDO and its enable change on TCK fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else if (!trst_s_n) begin
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else if (tck_fall) begin
      unique case (state_q)
        SH_IR: begin
          jtag_tdo_o    <= ir_sr_q[0];
          jtag_tdo_oe_o <= 1'b1;
        end
        SH_DR: begin
          jtag_tdo_o    <= dr_lsb;
          jtag_tdo_oe_o <= 1'b1;
        end
        default: begin
          jtag_tdo_o    <= 1'b0;
          jtag_tdo_oe_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_sync_tap.sv
// Testbench for jtag_sync_tap.
// Random and directed JTAG traffic against a TAP model.
module tb_jtag_sync_tap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        trst_n = 1'b1;
  logic        tdo;
  logic        tdo_oe;
  logic [31:0] cap_data = '0;
  logic        cap;
  logic        upd_valid;
  logic [31:0] upd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;

  always #5 clk = ~clk;

  jtag_sync_tap dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .jtag_tck_i       (tck),
    .jtag_tms_i       (tms),
    .jtag_tdi_i       (tdi),
    .jtag_trst_ni     (trst_n),
    .jtag_tdo_o       (tdo),
    .jtag_tdo_oe_o    (tdo_oe),
    .user_cap_data_i  (cap_data),
    .user_cap_o       (cap),
    .user_upd_valid_o (upd_valid),
    .user_upd_data_o  (upd_data)
  );

  // every clk cycle a pulse is high counts once
  always @(posedge clk) begin
    if (cap)       cap_cnt <= cap_cnt + 1;
    if (upd_valid) upd_cnt <= upd_cnt + 1;
  end

  // TAP model: states numbered
  // 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR
  // 6 PauseDR 7 Ex2DR 8 UpdDR 9 SelIR 10 CapIR
  // 11 ShIR 12 Ex1IR 13 PauseIR 14 Ex2IR 15 UpdIR
  int n0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4,
                  1, 10, 11, 11, 13, 13, 11, 1};
  int n1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8,
                  2, 0, 12, 12, 15, 14, 15, 2};

  int          m_state = 0;
  logic [4:0]  m_ir    = 5'h01;
  logic [4:0]  m_irsr  = '0;
  logic [63:0] m_dr    = '0;
  logic [31:0] m_upd   = '0;
  logic        m_tdo   = 1'b0;
  logic        m_oe    = 1'b0;
  int          m_cap   = 0;
  int          m_updn  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int dr_len();
    if (m_ir == 5'h01 || m_ir == 5'h10) return 32;
    return 1;
  endfunction

  task automatic model_rise(input logic t_ms,
                            input logic t_di);
    case (m_state)
      10: m_irsr = 5'b00001;
      11: m_irsr = {t_di, m_irsr[4:1]};
      15: m_ir = m_irsr;
      3: begin
        if (m_ir == 5'h01) m_dr = 64'h04F5484D;
        else if (m_ir == 5'h10) begin
          m_dr = {32'h0, cap_data};
          m_cap++;
        end else m_dr = '0;
      end
      4: m_dr = (m_dr >> 1) |
                (64'(t_di) << (dr_len() - 1));
      8: if (m_ir == 5'h10) begin
        m_upd = m_dr[31:0];
        m_updn++;
      end
      default: ;
    endcase
    m_state = t_ms ? n1[m_state] : n0[m_state];
    if (m_state == 0) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    m_oe  = (m_state == 4 || m_state == 11);
    m_tdo = (m_state == 4)  ? m_dr[0] :
            (m_state == 11) ? m_irsr[0] : 1'b0;
  endtask

  // one TCK period; returns TDO as seen at the rise
  task automatic clock(input logic t_ms,
                       input logic t_di,
                       output logic t_do);
    check("tdo", 64'(tdo), 64'(m_tdo));
    check("tdo_oe", 64'(tdo_oe), 64'(m_oe));
    check("upd_data", 64'(upd_data), 64'(m_upd));
    t_do = tdo;
    tms = t_ms;
    tdi = t_di;
    @(negedge clk);
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (4) @(negedge clk);
    tck = 1'b0;
    model_fall();
    repeat (5) @(negedge clk);
  endtask

  // from RTI, load an instruction, back to RTI
  task automatic scan_ir(input logic [4:0] v);
    logic d;
    clock(1, 0, d);
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    for (int i = 0; i < 5; i++) clock(i == 4, v[i], d);
    clock(1, 0, d);
    clock(0, 0, d);
  endtask

  // from RTI, shift n DR bits, back to RTI
  task automatic scan_dr(input int n,
                         input logic [63:0] din,
                         output logic [63:0] dout);
    logic d;
    dout = '0;
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    for (int i = 0; i < n; i++) begin
      clock(i == n - 1, din[i], d);
      dout[i] = d;
    end
    clock(1, 0, d);
    clock(0, 0, d);
  endtask

  task automatic to_rti();
    logic d;
    for (int i = 0; i < 5; i++) clock(1, 0, d);
    clock(0, 0, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tdo"}, 64'(tdo), 0);
    check({tag, "_oe"}, 64'(tdo_oe), 0);
    check({tag, "_cap"}, 64'(cap), 0);
    check({tag, "_updv"}, 64'(upd_valid), 0);
    check({tag, "_updd"}, 64'(upd_data), 0);
  endtask

  initial begin
    logic [63:0] dout;
    logic        d;
    int          c0;
    int          u0;

    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // IDCODE straight out of reset
    clock(0, 0, d);
    scan_dr(32, 64'h0, dout);
    check("idcode", dout[31:0], 32'h04F5484D);

    // BYPASS: one-bit delay, no USER pulses
    scan_ir(5'h1F);
    c0 = cap_cnt;
    u0 = upd_cnt;
    scan_dr(4, 64'b1101, dout);
    check("bypass_tdo", dout[3:0], 4'b1010);
    check("bypass_cap", 64'(cap_cnt - c0), 0);
    check("bypass_upd", 64'(upd_cnt - u0), 0);

    // USER update
    scan_ir(5'h10);
    u0 = upd_cnt;
    scan_dr(32, 64'hA5A50F0F, dout);
    check("user_upd_n", 64'(upd_cnt - u0), 1);
    check("user_upd_d", 64'(upd_data), 32'hA5A50F0F);

    // USER capture
    cap_data = 32'h12345678;
    c0 = cap_cnt;
    scan_dr(32, 64'(32'h0BADF00D), dout);
    check("user_cap_n", 64'(cap_cnt - c0), 1);
    check("user_cap_d", dout[31:0], 32'h12345678);

    // TRST mid-shift under USER
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    for (int i = 0; i < 5; i++) clock(0, 1, d);
    check("shift_oe", 64'(tdo_oe), 1);
    u0 = upd_cnt;
    trst_n = 1'b0;
    repeat (4) @(negedge clk);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_state = 0;
    m_ir    = 5'h01;
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
    check("trst_oe", 64'(tdo_oe), 0);
    check("trst_upd_n", 64'(upd_cnt - u0), 0);
    check("trst_upd_d", 64'(upd_data), 32'h0BADF00D);
    clock(0, 0, d);
    scan_dr(32, 64'h0, dout);
    check("trst_ir", dout[31:0], 32'h04F5484D);

    // five TMS=1 rises from PauseIR reach TLR
    scan_ir(5'h10);
    clock(1, 0, d);
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    clock(0, 1, d);
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    for (int i = 0; i < 5; i++) clock(1, 0, d);
    clock(0, 0, d);
    scan_dr(32, 64'h0, dout);
    check("pause_tlr", dout[31:0], 32'h04F5484D);

    // undefined code behaves as BYPASS, then rst_i
    scan_ir(5'h07);
    scan_dr(4, 64'b1101, dout);
    check("undef_tdo", dout[3:0], 4'b1010);
    clock(1, 0, d);
    clock(0, 0, d);
    clock(0, 0, d);
    clock(0, 1, d);
    clock(0, 1, d);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    m_state = 0;
    m_ir    = 5'h01;
    m_irsr  = '0;
    m_dr    = '0;
    m_upd   = '0;
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outputs("rst_after");

    // random traffic against the model
    for (int k = 0; k < 500; k++) begin
      case ($urandom_range(0, 24))
        0: begin
          to_rti();
          case ($urandom_range(0, 3))
            0: scan_ir(5'h01);
            1: scan_ir(5'h10);
            2: scan_ir(5'h1F);
            default: scan_ir(5'($urandom));
          endcase
        end
        1: cap_data = $urandom;
        default:
          clock($urandom_range(0, 3) == 0,
                1'($urandom), d);
      endcase
    end
    to_rti();
    repeat (4) @(negedge clk);
    check("cap_count", 64'(cap_cnt), 64'(m_cap));
    check("upd_count", 64'(upd_cnt), 64'(m_updn));
    check("final_upd_d", 64'(upd_data), 64'(m_upd));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
